// File: rtl/ts_image_mem.sv
// Timestamp/polarity image store: one word per DVS pixel, dual read / single write,
// zero-fill sweep after reset, registered read data with per-port valid strobes.
module ts_image_mem #(
  parameter int DVS_WIDTH      = 346,
  parameter int DVS_HEIGHT     = 260,
  parameter int WORD_SIZE      = 18,
  parameter int CLEAR_ON_RESET = 1,
  localparam int DEPTH         = DVS_WIDTH * DVS_HEIGHT,
  localparam int W_ADDR        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen,
  input  logic                 rw,
  input  logic [W_ADDR-1:0]    addr_port1,
  input  logic [W_ADDR-1:0]    addr_port2,
  input  logic [WORD_SIZE-1:0] write_data_mem,
  output logic [WORD_SIZE-1:0] read_data1_mem,
  output logic [WORD_SIZE-1:0] read_data2_mem,
  output logic                 read_data_mem_vld1,
  output logic                 read_data_mem_vld2,
  output logic                 init_done,
  output logic                 addr_err
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // One extra bit so the bound check stays correct when DEPTH is a power of two.
  localparam logic [W_ADDR:0]   DEPTH_EXT = (W_ADDR + 1)'(DEPTH);
  localparam logic [W_ADDR-1:0] LAST_ADDR = W_ADDR'(DEPTH - 1);

  logic [WORD_SIZE-1:0] mem [DEPTH];
  state_t               state;
  logic [W_ADDR-1:0]    sweep_cnt;
  logic                 accept;
  logic                 in_range1;
  logic                 in_range2;
  logic                 do_write;

  always_comb begin
    accept    = (state == ST_RUN) && !cen;
    in_range1 = {1'b0, addr_port1} < DEPTH_EXT;
    in_range2 = {1'b0, addr_port2} < DEPTH_EXT;
    do_write  = accept && !rw && in_range1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_INIT;
      sweep_cnt          <= '0;
      init_done          <= 1'b0;
      read_data_mem_vld1 <= 1'b0;
      read_data_mem_vld2 <= 1'b0;
      read_data1_mem     <= '0;
      read_data2_mem     <= '0;
      addr_err           <= 1'b0;
    end else begin
      read_data_mem_vld1 <= accept && rw;
      read_data_mem_vld2 <= accept;
      case (state)
        ST_INIT: begin
          if (CLEAR_ON_RESET == 0 || sweep_cnt == LAST_ADDR) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (rw)
              read_data1_mem <= in_range1 ? mem[addr_port1] : '0;
            // Port2 sees the word being written this cycle rather than the stale array value.
            if (!in_range2)
              read_data2_mem <= '0;
            else if (!rw && addr_port2 == addr_port1)
              read_data2_mem <= write_data_mem;
            else
              read_data2_mem <= mem[addr_port2];
            if (!in_range1 || !in_range2)
              addr_err <= 1'b1;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Array is not reset; the sweep clears it word by word while in INIT.
  always_ff @(posedge clk) begin
    if (state == ST_INIT && CLEAR_ON_RESET != 0)
      mem[sweep_cnt] <= '0;
    else if (do_write)
      mem[addr_port1] <= write_data_mem;
  end

endmodule

// File: tb/tb_ts_image_mem.sv
// Directed bench for ts_image_mem on a 4x3 image: reset sweep, table of RUN-mode
// vectors, and a mid-stream reset sequence.
module tb_ts_image_mem;

  localparam int W  = 18;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cen;
  logic          rw;
  logic [AW-1:0] addr_port1;
  logic [AW-1:0] addr_port2;
  logic [W-1:0]  write_data_mem;
  logic [W-1:0]  read_data1_mem;
  logic [W-1:0]  read_data2_mem;
  logic          read_data_mem_vld1;
  logic          read_data_mem_vld2;
  logic          init_done;
  logic          addr_err;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  ts_image_mem #(
    .DVS_WIDTH(4),
    .DVS_HEIGHT(3),
    .WORD_SIZE(W),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cen(cen),
    .rw(rw),
    .addr_port1(addr_port1),
    .addr_port2(addr_port2),
    .write_data_mem(write_data_mem),
    .read_data1_mem(read_data1_mem),
    .read_data2_mem(read_data2_mem),
    .read_data_mem_vld1(read_data_mem_vld1),
    .read_data_mem_vld2(read_data_mem_vld2),
    .init_done(init_done),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          cen;
    logic          rw;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [W-1:0]  wd;
    logic          v1;
    logic          v2;
    logic [W-1:0]  d1;
    logic [W-1:0]  d2;
    logic          err;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic c, input logic r, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2, input logic [W-1:0] wd);
    cen = c; rw = r; addr_port1 = a1; addr_port2 = a2; write_data_mem = wd;
  endtask

  int unsigned wait_cycles;
  logic        stray_vld;

  initial begin
    // cen rw a1 a2 wdata | vld1 vld2 rd1 rd2 addr_err
    vecs[0]  = '{1'b0, 1'b0, 4'd7,  4'd3,  18'h2ABCD, 1'b0, 1'b1, 18'h00000, 18'h00000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'd7,  4'd3,  18'h00000, 1'b1, 1'b1, 18'h2ABCD, 18'h00000, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 4'd4,  4'd4,  18'h12345, 1'b0, 1'b1, 18'h2ABCD, 18'h12345, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 4'd0,  4'd4,  18'h00001, 1'b0, 1'b1, 18'h2ABCD, 18'h12345, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 4'd1,  4'd2,  18'h00000, 1'b0, 1'b0, 18'h2ABCD, 18'h12345, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 4'd4,  4'd7,  18'h00000, 1'b0, 1'b0, 18'h2ABCD, 18'h12345, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 4'd9,  4'd0,  18'h3FFFF, 1'b0, 1'b0, 18'h2ABCD, 18'h12345, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4'd4,  4'd7,  18'h00000, 1'b1, 1'b1, 18'h12345, 18'h2ABCD, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 4'd9,  4'd0,  18'h00000, 1'b1, 1'b1, 18'h00000, 18'h00001, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 4'd12, 4'd11, 18'h15555, 1'b0, 1'b1, 18'h00000, 18'h00000, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 4'd12, 4'd15, 18'h00000, 1'b1, 1'b1, 18'h00000, 18'h00000, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 4'd11, 4'd7,  18'h00000, 1'b1, 1'b1, 18'h00000, 18'h2ABCD, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 4'd3,  4'd8,  18'h00000, 1'b0, 1'b0, 18'h00000, 18'h2ABCD, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 4'd2,  4'd5,  18'h3FFFF, 1'b0, 1'b1, 18'h00000, 18'h00000, 1'b1};

    // Reset, then hold a read of address 5 through the whole sweep.
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 4'd5, 4'd5, 18'h0);
    @(negedge clk);
    chk("rst_vld", {30'd0, read_data_mem_vld1, read_data_mem_vld2}, 32'd0);
    chk("rst_rd1", 32'(read_data1_mem), 32'd0);
    chk("rst_rd2", 32'(read_data2_mem), 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk($sformatf("init_vld_c%0d", i), {30'd0, read_data_mem_vld1, read_data_mem_vld2}, 32'd0);
      chk($sformatf("init_done_c%0d", i), {31'd0, init_done}, (i == 12) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk("first_rd_vld", {30'd0, read_data_mem_vld1, read_data_mem_vld2}, 32'd3);
    chk("first_rd1", 32'(read_data1_mem), 32'd0);
    chk("first_rd2", 32'(read_data2_mem), 32'd0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].cen, vecs[i].rw, vecs[i].a1, vecs[i].a2, vecs[i].wd);
      @(negedge clk);
      chk($sformatf("v%0d_vld1", i), {31'd0, read_data_mem_vld1}, {31'd0, vecs[i].v1});
      chk($sformatf("v%0d_vld2", i), {31'd0, read_data_mem_vld2}, {31'd0, vecs[i].v2});
      chk($sformatf("v%0d_rd1", i), 32'(read_data1_mem), 32'(vecs[i].d1));
      chk($sformatf("v%0d_rd2", i), 32'(read_data2_mem), 32'(vecs[i].d2));
      chk($sformatf("v%0d_addr_err", i), {31'd0, addr_err}, {31'd0, vecs[i].err});
    end

    // Strobes are single-cycle pulses: a read then idle.
    drive(1'b1, 1'b1, 4'd2, 4'd2, 18'h0);
    @(negedge clk);
    chk("pulse_vld_idle", {30'd0, read_data_mem_vld1, read_data_mem_vld2}, 32'd0);

    // Read back address 2, then reset while the strobes are high.
    drive(1'b0, 1'b1, 4'd2, 4'd2, 18'h0);
    @(negedge clk);
    chk("pre_rst_vld", {30'd0, read_data_mem_vld1, read_data_mem_vld2}, 32'd3);
    chk("pre_rst_rd1", 32'(read_data1_mem), 32'h3FFFF);
    chk("pre_rst_rd2", 32'(read_data2_mem), 32'h3FFFF);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", {30'd0, read_data_mem_vld1, read_data_mem_vld2}, 32'd0);
    chk("mid_rst_rd1", 32'(read_data1_mem), 32'd0);
    chk("mid_rst_init_done", {31'd0, init_done}, 32'd0);
    chk("mid_rst_addr_err", {31'd0, addr_err}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("held_rst_vld%0d", i), {30'd0, read_data_mem_vld1, read_data_mem_vld2}, 32'd0);
    end
    rst_n = 1'b1;
    wait_cycles = 0;
    stray_vld = 1'b0;
    while (!init_done && wait_cycles < 40) begin
      @(negedge clk);
      wait_cycles++;
      stray_vld = stray_vld | read_data_mem_vld1 | read_data_mem_vld2;
    end
    chk("reinit_done", {31'd0, init_done}, 32'd1);
    chk("reinit_cycles", wait_cycles, 32'd12);
    chk("reinit_no_vld", {31'd0, stray_vld}, 32'd0);
    @(negedge clk);
    chk("post_rst_vld", {30'd0, read_data_mem_vld1, read_data_mem_vld2}, 32'd3);
    chk("post_rst_rd1", 32'(read_data1_mem), 32'd0);
    chk("post_rst_rd2", 32'(read_data2_mem), 32'd0);
    chk("post_rst_addr_err", {31'd0, addr_err}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
